// File: rtl/div_seq_ctrl.sv
// Sequencer between execute-stage issue and the shared iterative divider.
// Latches one divide op, owns the ALU adder while busy, returns the tagged result.
module div_seq_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             div_en_o,
  output logic [2:0]       div_funct3_o,
  output logic [31:0]      div_a_o,
  output logic [31:0]      div_b_o,
  input  logic             div_finish_i,
  input  logic [31:0]      div_result_i,
  output logic             alu_grant_div_o,
  output logic             busy_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             timeout_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        data_q, data_d;

  // Next state, operand latching, result capture and watchdog
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    f3_d          = f3_q;
    a_d           = a_q;
    b_d           = b_q;
    tag_d         = tag_q;
    data_d        = data_q;
    req_ready_o   = 1'b0;
    div_en_o      = 1'b0;
    timeout_err_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = ~flush_i;
        if (req_valid_i && !flush_i) begin
          f3_d    = req_funct3_i;
          a_d     = req_a_i;
          b_d     = req_b_i;
          tag_d   = req_tag_i;
          cnt_d   = CNT_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        div_en_o = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (div_finish_i) begin
          data_d  = div_result_i;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          data_d        = '0;
          timeout_err_o = 1'b1;
          cnt_d         = '0;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (flush_i || resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign div_funct3_o    = f3_q;
  assign div_a_o         = a_q;
  assign div_b_o         = b_q;
  assign alu_grant_div_o = div_en_o;
  assign busy_o          = (state_q != IDLE);
  assign resp_valid_o    = (state_q == DONE);
  assign resp_data_o     = data_q;
  assign resp_tag_o      = tag_q;

endmodule
